alu_operand_stage: RTL
======================

# alu_operand_stage

Registered issue stage directly upstream of the execute ALU: accepts one decoded instruction per cycle over a valid/ready handshake and resolves ALU operands (register, PC, immediate, zero), with optional forwarding. It presents a registered ALU select code plus two 32-bit operands to the ALU. A 2-entry skid buffer decouples decode from ALU/memory backpressure and keeps the upstream ready path registered.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- I_clk  in  1  sole clock, rising edge
- I_rst_n  in  1  reset, synchronous and active-low
- I_flush  in  1  synchronous pipeline flush (branch/trap)
- I_valid  in  1  upstream instruction valid
- O_ready  out  1  stage can accept this cycle
- I_alusel  in  4  ALU operation, `ALU_*` encodings from alu.vh
- I_sel1  in  2  operand1 source: 0 rs1, 1 PC, 2 zero, 3 reserved (treated as zero)
- I_sel2  in  1  operand2 source: 0 rs2, 1 immediate
- I_rs1_addr, I_rs2_addr  in  5 each  source register indices
- I_rs1_data, I_rs2_data  in  32 each  register-file read data
- I_pc  in  32  instruction PC
- I_imm  in  32  sign-extended immediate
- I_rd_addr  in  5  destination register, passed through
- I_fwd_valid  in  1  forwarding source valid (result of older instruction)
- I_fwd_addr  in  5  forwarding destination index
- I_fwd_data  in  32  forwarding result
- O_valid  out  1  operands valid toward ALU
- I_ready  in  1  downstream accepts this cycle
- O_alusel  out  4  registered ALU select
- O_data1, O_data2  out  32 each  registered ALU operands
- O_rd_addr  out  5  registered destination index

## Operation
- Accept when I_valid && O_ready; transfer out when O_valid && I_ready.
- Operand1: rs1 value, I_pc, or 32'h0 per I_sel1. Operand2: rs2 value or I_imm per I_sel2.
- rs value = I_fwd_data if forwarding enabled, I_fwd_valid, I_fwd_addr == rs index, index != 0; else I_rsN_data. Resolved only at acceptance.
- Index 0 always yields 32'h0 when selected as rs, regardless of I_rsN_data.
- Shift ops (`ALU_SLL`, `ALU_SRL`, `ALU_SRA`): O_data2 = {27'b0, operand2[4:0]}. All other ops pass operand2 unmodified.
- Unknown I_alusel codes pass through unchanged (ALU defaults to ADD).
- State machine on occupancy: EMPTY (no entries), ONE (output reg valid), FULL (output reg + skid entry).
  - EMPTY: accept -> ONE.
  - ONE: accept and no transfer -> FULL (new entry to skid); accept with transfer -> ONE (new entry to output); transfer only -> EMPTY.
  - FULL: O_ready = 0; transfer -> ONE, skid moves to output.
- O_ready = 1 in EMPTY and ONE, 0 in FULL and while I_rst_n low.
- Order preserved: skid entry is always older than any later acceptance.
- I_flush: next state EMPTY, all entries discarded, any same-cycle acceptance dropped; flush beats accept and transfer.

## Timing
- Latency 1 cycle: instruction accepted at edge N is on outputs with O_valid=1 after edge N.
- Throughput 1 instruction/cycle with I_ready held high.
- O_ready depends only on state register (no combinational I_ready->O_ready path).
- Reset (edge with I_rst_n=0): state EMPTY, O_valid=0, O_alusel=4'h0, O_data1=O_data2=32'h0, O_rd_addr=0, skid cleared; mid-operation reset discards all entries.
- Outputs hold stable while O_valid && !I_ready.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding mux compiled in as described.
- Undefined: I_fwd_* ports remain but are ignored; rs values come only from I_rsN_data (x0 still forced to zero).

## Test plan
- Reset then I_valid=1, `ALU_ADD`, sel1=0, rs1=x1 data 5, sel2=1, imm=7 -> next cycle O_valid=1, O_data1=5, O_data2=7, O_rd_addr passed.
- `ALU_SRA`, rs2 data 32'h0000_0123 -> O_data2=32'h0000_0003; same with `ALU_XOR` -> 32'h0000_0123.
- I_ready=0 for 3 cycles while feeding A,B,C -> A on output, B in skid, O_ready=0 after second accept, C held; release -> A, B, C out in order, no loss/duplication.
- FWD_EN: rs1=x3, I_rs1_data=1, I_fwd_valid=1, addr=3, data=99 -> O_data1=99; fwd addr=0 with rs1=x0 -> O_data1=0.
- FULL state, assert I_flush with I_valid=1 -> next cycle O_valid=0, O_ready=1, nothing emitted.
- Drop I_rst_n for one edge while FULL -> all outputs zero, O_valid=0, O_ready=1 after release.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the execute ALU: resolves operands, registers them, and holds a second entry in a skid buffer.
// Optional feature macro: ALU_OPERAND_FWD_EN compiles in the result-forwarding mux on rs1/rs2.
module alu_operand_stage (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_flush,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic [3:0]  I_alusel,
    input  logic [1:0]  I_sel1,
    input  logic        I_sel2,
    input  logic [4:0]  I_rs1_addr,
    input  logic [4:0]  I_rs2_addr,
    input  logic [31:0] I_rs1_data,
    input  logic [31:0] I_rs2_data,
    input  logic [31:0] I_pc,
    input  logic [31:0] I_imm,
    input  logic [4:0]  I_rd_addr,
    input  logic        I_fwd_valid,
    input  logic [4:0]  I_fwd_addr,
    input  logic [31:0] I_fwd_data,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [3:0]  O_alusel,
    output logic [31:0] O_data1,
    output logic [31:0] O_data2,
    output logic [4:0]  O_rd_addr
);
    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [3:0]        alusel;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [4:0]        rd_addr;
    } entry_t;

    state_t state, state_nxt;
    entry_t in_p0;
    entry_t out_p1;
    entry_t skid_p1;

    logic              acc, xfer;
    logic              ld_out_in, ld_out_skid, ld_skid;
    logic [DATA_W-1:0] rs1_val_p0, rs2_val_p0;
    logic [DATA_W-1:0] op1_p0, op2_p0;

    // Shifters only consume the low five bits of the shift amount.
    function automatic logic [DATA_W-1:0] shamt_clip(input logic [3:0] op,
                                                     input logic [DATA_W-1:0] v);
        if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA)
            return {27'b0, v[4:0]};
        return v;
    endfunction

    // ---- stage p0: operand resolution on the incoming instruction ----
    always_comb begin
        rs1_val_p0 = (I_rs1_addr == 5'd0) ? '0 : I_rs1_data;
        rs2_val_p0 = (I_rs2_addr == 5'd0) ? '0 : I_rs2_data;
`ifdef ALU_OPERAND_FWD_EN
        if (I_fwd_valid && I_rs1_addr != 5'd0 && I_fwd_addr == I_rs1_addr)
            rs1_val_p0 = I_fwd_data;
        if (I_fwd_valid && I_rs2_addr != 5'd0 && I_fwd_addr == I_rs2_addr)
            rs2_val_p0 = I_fwd_data;
`endif
        case (I_sel1)
            2'd0:    op1_p0 = rs1_val_p0;
            2'd1:    op1_p0 = I_pc;
            default: op1_p0 = '0;
        endcase
        op2_p0 = I_sel2 ? I_imm : rs2_val_p0;

        in_p0.alusel  = I_alusel;
        in_p0.data1   = op1_p0;
        in_p0.data2   = shamt_clip(I_alusel, op2_p0);
        in_p0.rd_addr = I_rd_addr;
    end

`ifndef ALU_OPERAND_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{I_fwd_valid, I_fwd_addr, I_fwd_data};
`endif

    assign O_valid = (state != EMPTY);
    assign O_ready = I_rst_n && (state != FULL);
    assign acc     = I_valid && O_ready;
    assign xfer    = O_valid && I_ready;

    always_comb begin
        state_nxt   = state;
        ld_out_in   = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    ld_out_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && !xfer) begin
                    state_nxt = FULL;
                    ld_skid   = 1'b1;
                end else if (acc && xfer) begin
                    ld_out_in = 1'b1;
                end else if (xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_nxt   = ONE;
                    ld_out_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush discards everything, including a same-cycle acceptance.
        if (I_flush) begin
            state_nxt   = EMPTY;
            ld_out_in   = 1'b0;
            ld_out_skid = 1'b0;
            ld_skid     = 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // ---- stage p1: output register and skid entry ----
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            out_p1  <= '0;
            skid_p1 <= '0;
        end else begin
            if (ld_out_in)
                out_p1 <= in_p0;
            else if (ld_out_skid)
                out_p1 <= skid_p1;
            if (ld_skid)
                skid_p1 <= in_p0;
        end
    end

    assign O_alusel  = out_p1.alusel;
    assign O_data1   = out_p1.data1;
    assign O_data2   = out_p1.data2;
    assign O_rd_addr = out_p1.rd_addr;

endmodule
